// File: rtl/gpr_file_pkg.sv
// gpr_file_pkg: shared register-file constants, pipeline records and helpers
package gpr_file_pkg;
  localparam int GPR_NUM    = 32;
  localparam int XLEN_DEF   = 64;
  localparam int PEND_W_DEF = 2;
  typedef logic [4:0] gpr_idx_t;
  typedef struct packed {
    logic     valid;
    logic     rd_en;
    gpr_idx_t rd;
  } gpr_issue_t;
  typedef struct packed {
    logic                valid;
    gpr_idx_t            rd;
    logic                discard;
    logic [XLEN_DEF-1:0] value;
  } gpr_wb_t;
  // One-hot select of a register; x0 never selects anything since it has no state.
  function automatic logic [GPR_NUM-1:0] reg_onehot(input logic en, input gpr_idx_t rd);
    return (en && rd != '0) ? (GPR_NUM'(1) << rd) : '0;
  endfunction
endpackage

// File: rtl/gpr_file_if.sv
// gpr_read: decode-to-register-file source read port
interface gpr_read import gpr_file_pkg::*; #(parameter int XLEN = XLEN_DEF);
  logic            rs1_en;
  gpr_idx_t        rs1;
  logic            rs2_en;
  gpr_idx_t        rs2;
  logic [XLEN-1:0] rs1_value;
  logic [XLEN-1:0] rs2_value;
  logic            reg_read_busy;
  modport master (output rs1_en, rs1, rs2_en, rs2, input rs1_value, rs2_value, reg_read_busy);
  modport slave  (input rs1_en, rs1, rs2_en, rs2, output rs1_value, rs2_value, reg_read_busy);
endinterface

// File: rtl/gpr_file_scoreboard.sv
// gpr_scoreboard: per-register in-flight write counters with saturating inc/dec
module gpr_scoreboard import gpr_file_pkg::*; #(
  parameter int PEND_W = PEND_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               inc_en,
  input  gpr_idx_t           inc_rd,
  input  logic               dec_en,
  input  gpr_idx_t           dec_rd,
  output logic [GPR_NUM-1:1] pend_nonzero,
  output logic [GPR_NUM-1:1] pend_is_one,
  output logic               issue_ready
);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  logic [PEND_W-1:0]  pend_q [GPR_NUM-1:1];
  logic [PEND_W-1:0]  pend_d [GPR_NUM-1:1];
  logic [GPR_NUM-1:0] up, dn, sat;
  assign up = reg_onehot(inc_en, inc_rd);
  assign dn = reg_onehot(dec_en, dec_rd);
  assign issue_ready = !sat[inc_rd];
  // Next counter values; an inc and dec on the same register cancel, and both ends saturate.
  always_comb begin
    pend_d       = pend_q;
    sat          = '0;
    pend_nonzero = '0;
    pend_is_one  = '0;
    for (int i = 1; i < GPR_NUM; i++) begin
      sat[i]          = pend_q[i] == PEND_MAX;
      pend_nonzero[i] = pend_q[i] != '0;
      pend_is_one[i]  = pend_q[i] == PEND_W'(1);
      if (up[i] && !dn[i] && !sat[i]) pend_d[i] = pend_q[i] + 1'b1;
      else if (dn[i] && !up[i] && pend_nonzero[i]) pend_d[i] = pend_q[i] - 1'b1;
    end
  end
  // Counter state, cleared immediately on reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) for (int i = 1; i < GPR_NUM; i++) pend_q[i] <= '0;
    else pend_q <= pend_d;
  end
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset) (up & sat) == '0);
  a_no_underflow: assert property (@(posedge clock) disable iff (!reset) (dn & ~{pend_nonzero, 1'b0}) == '0);
endmodule

// File: rtl/gpr_file.sv
// gpr_file: integer register file with two bypassed source reads and in-flight scoreboard
module gpr_file import gpr_file_pkg::*; #(
  parameter int XLEN   = XLEN_DEF,
  parameter int PEND_W = PEND_W_DEF
) (
  input  logic            clock,
  input  logic            reset,
  gpr_read.slave          gpr_if,
  input  logic            issue_valid,
  input  logic            issue_rd_en,
  input  gpr_idx_t        issue_rd,
  output logic            issue_ready,
  input  logic            wb_valid,
  input  gpr_idx_t        wb_rd,
  input  logic            wb_discard,
  input  logic [XLEN-1:0] wb_value
);
  gpr_issue_t         iss;
  logic [GPR_NUM-1:1] pend_nonzero, pend_is_one;
  logic [GPR_NUM-1:0] nz, one, wr;
  logic [XLEN-1:0]    regs_q [GPR_NUM-1:1];
  logic [XLEN-1:0]    regs_d [GPR_NUM-1:1];
  logic [XLEN-1:0]    rf     [GPR_NUM];
  logic               wb_live, bypass1, bypass2, busy1, busy2;
  assign iss     = '{valid: issue_valid, rd_en: issue_rd_en, rd: issue_rd};
  assign wb_live = wb_valid && !wb_discard;
  assign wr      = reg_onehot(wb_live, wb_rd);
  assign nz      = {pend_nonzero, 1'b0};
  assign one     = {pend_is_one, 1'b0};
  gpr_scoreboard #(.PEND_W(PEND_W)) u_sb (
    .clock        (clock),
    .reset        (reset),
    .inc_en       (iss.valid && iss.rd_en),
    .inc_rd       (iss.rd),
    .dec_en       (wb_valid),
    .dec_rd       (wb_rd),
    .pend_nonzero (pend_nonzero),
    .pend_is_one  (pend_is_one),
    .issue_ready  (issue_ready)
  );
  // Read view of the array with a hardwired zero for x0, plus the writeback update.
  always_comb begin
    rf[0]  = '0;
    regs_d = regs_q;
    for (int i = 1; i < GPR_NUM; i++) begin
      rf[i] = regs_q[i];
      if (wr[i]) regs_d[i] = wb_value;
    end
  end
  // Only the last outstanding write may be forwarded; older ones would be stale.
  always_comb begin
    bypass1              = wb_live && wb_rd == gpr_if.rs1 && one[gpr_if.rs1];
    bypass2              = wb_live && wb_rd == gpr_if.rs2 && one[gpr_if.rs2];
    busy1                = gpr_if.rs1_en && nz[gpr_if.rs1] && !bypass1;
    busy2                = gpr_if.rs2_en && nz[gpr_if.rs2] && !bypass2;
    gpr_if.rs1_value     = bypass1 ? wb_value : rf[gpr_if.rs1];
    gpr_if.rs2_value     = bypass2 ? wb_value : rf[gpr_if.rs2];
    gpr_if.reg_read_busy = busy1 | busy2;
  end
  // Architectural registers x1..x31.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) for (int i = 1; i < GPR_NUM; i++) regs_q[i] <= '0;
    else regs_q <= regs_d;
  end
endmodule

// File: tb/tb_gpr_file.sv
// tb_gpr_file: directed self-checking bench for gpr_file
module tb_gpr_file;
  logic        clock = 0;
  logic        reset = 0;
  logic        issue_valid = 0, issue_rd_en = 0, wb_valid = 0, wb_discard = 0;
  logic [4:0]  issue_rd = 0, wb_rd = 0;
  logic [63:0] wb_value = 0;
  logic        issue_ready;
  int          n_tests = 0, n_fail = 0;
  gpr_read #(.XLEN(64)) gif ();
  gpr_file #(.XLEN(64), .PEND_W(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .gpr_if      (gif),
    .issue_valid (issue_valid),
    .issue_rd_en (issue_rd_en),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_discard  (wb_discard),
    .wb_value    (wb_value)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask
  task automatic idle();
    issue_valid = 0; issue_rd_en = 0; issue_rd = 0;
    wb_valid = 0; wb_discard = 0; wb_rd = 0; wb_value = 0;
  endtask
  task automatic issue(input logic [4:0] rd);
    issue_valid = 1; issue_rd_en = 1; issue_rd = rd;
  endtask
  task automatic wb(input logic [4:0] rd, input logic disc, input logic [63:0] v);
    wb_valid = 1; wb_rd = rd; wb_discard = disc; wb_value = v;
  endtask
  task automatic rd_src(input logic e1, input logic [4:0] r1, input logic e2, input logic [4:0] r2);
    gif.rs1_en = e1; gif.rs1 = r1; gif.rs2_en = e2; gif.rs2 = r2;
  endtask
  initial begin
    rd_src(0, 0, 0, 0);
    cyc(); cyc();
    reset = 1;
    rd_src(1, 5, 1, 0);
    #1;
    chk("reset_rs1", gif.rs1_value, 64'h0);
    chk("reset_rs2", gif.rs2_value, 64'h0);
    chk("reset_busy", gif.reg_read_busy, 1'b0);
    chk("reset_ready", issue_ready, 1'b1);
    issue(7); rd_src(0, 0, 0, 0);
    cyc(); idle(); rd_src(1, 7, 0, 0); #1;
    chk("x7_busy", gif.reg_read_busy, 1'b1);
    wb(7, 0, 64'hDEAD_BEEF); #1;
    chk("x7_bypass_busy", gif.reg_read_busy, 1'b0);
    chk("x7_bypass_val", gif.rs1_value, 64'hDEAD_BEEF);
    cyc(); idle(); rd_src(0, 0, 1, 7); #1;
    chk("x7_array_val", gif.rs2_value, 64'hDEAD_BEEF);
    chk("x7_array_busy", gif.reg_read_busy, 1'b0);
    issue(3); cyc(); #1;
    chk("x3_ready_p1", issue_ready, 1'b1);
    cyc(); cyc(); idle(); issue_rd = 3; rd_src(1, 3, 0, 0); #1;
    chk("x3_ready_sat", issue_ready, 1'b0);
    chk("x3_busy_p3", gif.reg_read_busy, 1'b1);
    wb(3, 0, 64'h33); #1;
    chk("x3_no_bypass_p3", gif.reg_read_busy, 1'b1);
    cyc(); wb_valid = 0; #1;
    chk("x3_ready_p2", issue_ready, 1'b1);
    wb(3, 0, 64'h34); cyc(); wb(3, 0, 64'h35); #1;
    chk("x3_bypass_p1_busy", gif.reg_read_busy, 1'b0);
    chk("x3_bypass_p1_val", gif.rs1_value, 64'h35);
    cyc(); idle(); #1;
    chk("x3_clear_busy", gif.reg_read_busy, 1'b0);
    chk("x3_array_val", gif.rs1_value, 64'h35);
    issue(9); cyc(); idle(); wb(9, 0, 64'h11); cyc(); idle();
    issue(9); cyc(); idle(); rd_src(0, 0, 1, 9); #1;
    chk("x9_busy", gif.reg_read_busy, 1'b1);
    wb(9, 1, 64'h55); #1;
    chk("x9_discard_busy", gif.reg_read_busy, 1'b1);
    cyc(); idle(); #1;
    chk("x9_after_discard_busy", gif.reg_read_busy, 1'b0);
    chk("x9_kept_val", gif.rs2_value, 64'h11);
    issue(4); rd_src(0, 0, 0, 0); cyc();
    issue(4); wb(4, 0, 64'h42); rd_src(1, 4, 0, 0); #1;
    chk("x4_same_cycle_busy", gif.reg_read_busy, 1'b0);
    chk("x4_same_cycle_val", gif.rs1_value, 64'h42);
    cyc(); idle(); #1;
    chk("x4_still_pending", gif.reg_read_busy, 1'b1);
    wb(4, 1, 64'h99); cyc(); idle(); #1;
    chk("x4_drained_busy", gif.reg_read_busy, 1'b0);
    chk("x4_array_val", gif.rs1_value, 64'h42);
    issue(0); wb(0, 0, 64'hFF); rd_src(1, 0, 1, 0); #1;
    chk("x0_ready", issue_ready, 1'b1);
    chk("x0_bypass_val", gif.rs1_value, 64'h0);
    chk("x0_busy", gif.reg_read_busy, 1'b0);
    cyc(); idle(); #1;
    chk("x0_after_val", gif.rs2_value, 64'h0);
    chk("x0_after_busy", gif.reg_read_busy, 1'b0);
    issue(12); cyc(); cyc(); idle(); rd_src(0, 12, 0, 0); #1;
    chk("x12_disabled_busy", gif.reg_read_busy, 1'b0);
    rd_src(0, 0, 1, 12); #1;
    chk("x12_busy", gif.reg_read_busy, 1'b1);
    reset = 0; rd_src(1, 12, 1, 4); #1;
    chk("rst_busy", gif.reg_read_busy, 1'b0);
    chk("rst_x4", gif.rs2_value, 64'h0);
    chk("rst_x12", gif.rs1_value, 64'h0);
    cyc(); reset = 1; rd_src(1, 3, 1, 12); cyc(); #1;
    chk("post_rst_busy", gif.reg_read_busy, 1'b0);
    chk("post_rst_x3", gif.rs1_value, 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
